// File: rtl/atm_sched_pkg.sv
// Shared definitions for the ATM transaction scheduler.
//   OP_*    : terminal operation encodings carried on the op bus
//   S_*     : scheduler FSM state encodings
//   BAL_W   : default balance/amount width
//   MAX_BAL : largest legal balance (2**BAL_W - 1)
package atm_sched_pkg;

  localparam int BAL_W   = 11;
  localparam int MAX_BAL = (1 << BAL_W) - 1;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_DEPOSIT  = 2'd2,
    OP_TRANSFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_SRC  = 3'd1,
    S_CHK_SRC = 3'd2,
    S_RD_DST  = 3'd3,
    S_CHK_DST = 3'd4,
    S_WR_DST  = 3'd5,
    S_WR_SRC  = 3'd6,
    S_RESP    = 3'd7
  } state_e;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after rr_ptr, wrapping around.
// Ports:
//   req       in  N_TERM  request vector
//   rr_ptr    in  PTR_W   highest-priority requester this round
//   gnt       out N_TERM  one-hot grant (all zero when no request)
//   gnt_idx   out PTR_W   binary index of the granted requester
//   gnt_valid out 1       at least one request present
module atm_rr_arbiter #(
  parameter int N_TERM = 4,
  parameter int PTR_W  = 2
) (
  input  logic [N_TERM-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [N_TERM-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    // Scan N_TERM positions starting at rr_ptr; the first hit wins.
    for (int k = 0; k < N_TERM; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_TERM);
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/atm_txn_scheduler.sv
// ATM transaction scheduler: shares one single-port balance store among
// N_TERM terminal sessions. One request is granted at a time (round robin)
// and its read/check/write steps run to completion before the next grant,
// so every transaction is atomic with respect to the other terminals.
//
// Handshake: a terminal raises req[i] with op/idx/amount stable and holds it
// until it samples done[i]. done[i] is a one-cycle pulse; err and bal_out are
// valid only in that cycle. req is sampled only while the scheduler is idle,
// so dropping req on the done-sampling edge prevents a repeat grant, while
// keeping it high requests another transaction.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req, op, src_idx,     per-terminal request level and transaction fields
//   dst_idx, amount
//   sess_end              per-terminal session-end pulse (daily-limit clear)
//   done, err, bal_out    completion pulse, reject flag, resulting source balance
//   busy                  scheduler not idle
//   mem_addr, mem_rd,     balance store port; mem_rdata arrives one cycle
//   mem_wr, mem_wdata,    after mem_rd
//   mem_rdata
//
// Build option: define ATM_DAILY_LIMIT_EN to add a per-terminal withdrawn
// total that rejects WITHDRAW/TRANSFER exceeding DAILY_LIMIT per session.
module atm_txn_scheduler #(
  parameter int N_TERM      = 4,
  parameter int IDX_W       = 4,
  parameter int BAL_W       = atm_sched_pkg::BAL_W,
  parameter int DAILY_LIMIT = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_TERM-1:0]         req,
  input  logic [2*N_TERM-1:0]       op,
  input  logic [IDX_W*N_TERM-1:0]   src_idx,
  input  logic [IDX_W*N_TERM-1:0]   dst_idx,
  input  logic [BAL_W*N_TERM-1:0]   amount,
  input  logic [N_TERM-1:0]         sess_end,
  output logic [N_TERM-1:0]         done,
  output logic                      err,
  output logic [BAL_W-1:0]          bal_out,
  output logic                      busy,
  output logic [IDX_W-1:0]          mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [BAL_W-1:0]          mem_wdata,
  input  logic [BAL_W-1:0]          mem_rdata
);

  import atm_sched_pkg::*;

  localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  // Arbiter
  logic [N_TERM-1:0] arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_valid;

  // FSM and latched transaction
  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_TERM-1:0] gnt_q, gnt_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic [IDX_W-1:0]  dst_q, dst_d;
  logic [BAL_W-1:0]  amt_q, amt_d;
  logic [BAL_W-1:0]  src_bal_q, src_bal_d;  // source balance as read
  logic [BAL_W-1:0]  res_bal_q, res_bal_d;  // source balance after success

  // Registered outputs
  logic [N_TERM-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [BAL_W-1:0]  bal_out_q, bal_out_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [BAL_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Read data plus amount, one bit wider so the carry flags overflow.
  logic [BAL_W:0]    rd_sum;
  logic              lim_err;

  assign rd_sum = {1'b0, mem_rdata} + {1'b0, amt_q};

  atm_rr_arbiter #(
    .N_TERM (N_TERM),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    amt_d       = amt_q;
    src_bal_d   = src_bal_q;
    res_bal_d   = res_bal_q;
    done_d      = '0;
    err_d       = 1'b0;
    bal_out_d   = '0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          for (int i = 0; i < N_TERM; i++) begin
            if (arb_gnt[i]) begin
              op_d  = op_e'(op[2*i +: 2]);
              src_d = src_idx[IDX_W*i +: IDX_W];
              dst_d = dst_idx[IDX_W*i +: IDX_W];
              amt_d = amount[BAL_W*i +: BAL_W];
            end
          end
          gnt_d      = arb_gnt;
          rr_ptr_d   = (arb_idx == PTR_W'(N_TERM - 1)) ? '0 : arb_idx + 1'b1;
          mem_addr_d = src_d;
          mem_rd_d   = 1'b1;
          state_d    = S_RD_SRC;
        end
      end

      S_RD_SRC: state_d = S_CHK_SRC;

      S_CHK_SRC: begin
        src_bal_d = mem_rdata;
        case (op_q)
          OP_BALANCE: begin
            done_d    = gnt_q;
            bal_out_d = mem_rdata;
            state_d   = S_RESP;
          end
          OP_WITHDRAW: begin
            if ((amt_q > mem_rdata) || lim_err) begin
              done_d    = gnt_q;
              err_d     = 1'b1;
              bal_out_d = mem_rdata;
              state_d   = S_RESP;
            end else begin
              res_bal_d   = mem_rdata - amt_q;
              mem_addr_d  = src_q;
              mem_wr_d    = 1'b1;
              mem_wdata_d = mem_rdata - amt_q;
              state_d     = S_WR_SRC;
            end
          end
          OP_DEPOSIT: begin
            if (rd_sum[BAL_W]) begin
              done_d    = gnt_q;
              err_d     = 1'b1;
              bal_out_d = mem_rdata;
              state_d   = S_RESP;
            end else begin
              res_bal_d   = rd_sum[BAL_W-1:0];
              mem_addr_d  = src_q;
              mem_wr_d    = 1'b1;
              mem_wdata_d = rd_sum[BAL_W-1:0];
              state_d     = S_WR_SRC;
            end
          end
          default: begin // OP_TRANSFER
            if ((src_q == dst_q) || (amt_q > mem_rdata) || lim_err) begin
              done_d    = gnt_q;
              err_d     = 1'b1;
              bal_out_d = mem_rdata;
              state_d   = S_RESP;
            end else begin
              // Source debit is held until the destination check passes.
              res_bal_d  = mem_rdata - amt_q;
              mem_addr_d = dst_q;
              mem_rd_d   = 1'b1;
              state_d    = S_RD_DST;
            end
          end
        endcase
      end

      S_RD_DST: state_d = S_CHK_DST;

      S_CHK_DST: begin
        if (rd_sum[BAL_W]) begin
          done_d    = gnt_q;
          err_d     = 1'b1;
          bal_out_d = src_bal_q;
          state_d   = S_RESP;
        end else begin
          mem_addr_d  = dst_q;
          mem_wr_d    = 1'b1;
          mem_wdata_d = rd_sum[BAL_W-1:0];
          state_d     = S_WR_DST;
        end
      end

      S_WR_DST: begin
        mem_addr_d  = src_q;
        mem_wr_d    = 1'b1;
        mem_wdata_d = res_bal_q;
        state_d     = S_WR_SRC;
      end

      S_WR_SRC: begin
        done_d    = gnt_q;
        bal_out_d = res_bal_q;
        state_d   = S_RESP;
      end

      default: state_d = S_IDLE; // S_RESP
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      op_q        <= OP_BALANCE;
      src_q       <= '0;
      dst_q       <= '0;
      amt_q       <= '0;
      src_bal_q   <= '0;
      res_bal_q   <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      bal_out_q   <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      amt_q       <= amt_d;
      src_bal_q   <= src_bal_d;
      res_bal_q   <= res_bal_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bal_out_q   <= bal_out_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  // Per-terminal total withdrawn (or transferred out) this session.
  logic [BAL_W:0]    wd_total_q [N_TERM];
  logic [BAL_W:0]    wd_total_d [N_TERM];
  logic [N_TERM-1:0] end_pend_q, end_pend_d;
  logic [BAL_W+1:0]  lim_sum;
  logic              op_counts;

  assign op_counts = (op_q == OP_WITHDRAW) || (op_q == OP_TRANSFER);

  always_comb begin
    lim_sum = '0;
    for (int i = 0; i < N_TERM; i++) begin
      if (gnt_q[i]) lim_sum = {1'b0, wd_total_q[i]} + {2'b00, amt_q};
    end
    lim_err = op_counts && (lim_sum > (BAL_W+2)'(DAILY_LIMIT));
  end

  // A session end seen while that terminal is mid-transaction is deferred
  // until the RESP cycle so the in-flight amount is counted and then cleared.
  always_comb begin
    for (int i = 0; i < N_TERM; i++) begin
      wd_total_d[i] = wd_total_q[i];
      end_pend_d[i] = end_pend_q[i];
      if ((state_q != S_IDLE) && gnt_q[i]) begin
        if (state_q == S_RESP) begin
          if (!err_q && op_counts) wd_total_d[i] = wd_total_q[i] + {1'b0, amt_q};
          if (end_pend_q[i] || sess_end[i]) begin
            wd_total_d[i] = '0;
            end_pend_d[i] = 1'b0;
          end
        end else if (sess_end[i]) begin
          end_pend_d[i] = 1'b1;
        end
      end else if (sess_end[i]) begin
        wd_total_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TERM; i++) wd_total_q[i] <= '0;
      end_pend_q <= '0;
    end else begin
      for (int i = 0; i < N_TERM; i++) wd_total_q[i] <= wd_total_d[i];
      end_pend_q <= end_pend_d;
    end
  end
`else
  // No per-session accounting: sess_end and DAILY_LIMIT have no effect.
  logic unused_cfg;
  assign lim_err    = 1'b0;
  assign unused_cfg = (^sess_end) ^ (DAILY_LIMIT != 0);
`endif

  assign done      = done_q;
  assign err       = err_q;
  assign bal_out   = bal_out_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_atm_txn_scheduler.sv
// Directed testbench for atm_txn_scheduler with a behavioural balance store,
// an expected-response queue filled by the drivers and a done monitor.
module tb_atm_txn_scheduler;
  import atm_sched_pkg::*;

  localparam int N_TERM = 4;
  localparam int IDX_W  = 4;
  localparam int EXP_W  = 2 + 1 + BAL_W;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_TERM-1:0]       req      = '0;
  logic [2*N_TERM-1:0]     op       = '0;
  logic [IDX_W*N_TERM-1:0] src_idx  = '0;
  logic [IDX_W*N_TERM-1:0] dst_idx  = '0;
  logic [BAL_W*N_TERM-1:0] amount   = '0;
  logic [N_TERM-1:0]       sess_end = '0;
  logic [N_TERM-1:0]       done;
  logic                    err;
  logic [BAL_W-1:0]        bal_out;
  logic                    busy;
  logic [IDX_W-1:0]        mem_addr;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [BAL_W-1:0]        mem_wdata;
  logic [BAL_W-1:0]        mem_rdata = '0;

  atm_txn_scheduler #(
    .N_TERM (N_TERM),
    .IDX_W  (IDX_W),
    .BAL_W  (BAL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .src_idx   (src_idx),
    .dst_idx   (dst_idx),
    .amount    (amount),
    .sess_end  (sess_end),
    .done      (done),
    .err       (err),
    .bal_out   (bal_out),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Balance store model: 1-cycle read latency, counts writes.
  logic [BAL_W-1:0] store [16];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_wr) begin
      store[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd) mem_rdata <= store[mem_addr];
  end

  // Scoreboard
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (done != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%b with nothing expected (t=%0t)", done, $time);
      end else begin
        exp_e = exp_q.pop_front();
        chk("done_term", int'(done), 1 << int'(exp_e[EXP_W-1 -: 2]));
        chk("err", int'(err), int'(exp_e[BAL_W]));
        chk("bal_out", int'(bal_out), int'(exp_e[BAL_W-1:0]));
      end
    end
  end

  // Drivers
  task automatic set_term(input int t, input op_e o, input int s, input int d, input int a);
    op[2*t +: 2]             = o;
    src_idx[IDX_W*t +: IDX_W] = s[IDX_W-1:0];
    dst_idx[IDX_W*t +: IDX_W] = d[IDX_W-1:0];
    amount[BAL_W*t +: BAL_W]  = a[BAL_W-1:0];
  endtask

  task automatic push_exp(input int t, input int e_err, input int e_bal);
    exp_q.push_back({t[1:0], e_err[0], e_bal[BAL_W-1:0]});
  endtask

  // One transaction from an idle scheduler; called and returns at a negedge.
  task automatic txn(input int t, input op_e o, input int s, input int d, input int a,
                     input int e_err, input int e_bal, input int e_lat, input int e_wr);
    int lat;
    int w0;
    bit got;
    w0  = wr_cnt;
    lat = 0;
    got = 1'b0;
    push_exp(t, e_err, e_bal);
    set_term(t, o, s, d, a);
    req[t] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (done[t]) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    req[t] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: terminal %0d got no done within 40 cycles", t);
    end
    @(negedge clk);
    chk("latency", lat + 1, e_lat);
    chk("writes", wr_cnt - w0, e_wr);
  endtask

  int n_done;
  int cyc;
  int last;

  initial begin
    for (int i = 0; i < 16; i++) store[i] <= '0;
    store[3]  <= 11'd500;
    store[5]  <= 11'd2000;
    store[7]  <= 11'd1500;
    store[9]  <= 11'd300;
    store[10] <= 11'd7;
    store[11] <= 11'd107;
    store[12] <= 11'd207;
    store[13] <= 11'd307;

    // Reset state
    #12;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_bal_out", int'(bal_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Balance enquiry
    txn(0, OP_BALANCE, 3, 0, 0, 0, 500, 3, 0);

    // Withdraw: success, reject, exact balance
    txn(1, OP_WITHDRAW, 3, 0, 100, 0, 400, 4, 1);
    chk("store3_after_wd", int'(store[3]), 400);
    txn(1, OP_WITHDRAW, 3, 0, 2000, 1, 400, 3, 0);
    txn(1, OP_WITHDRAW, 9, 0, 300, 0, 0, 4, 1);

    // Deposit up to the ceiling, then one past it
    txn(1, OP_DEPOSIT, 9, 0, MAX_BAL, 0, MAX_BAL, 4, 1);
    txn(1, OP_DEPOSIT, 9, 0, 1, 1, MAX_BAL, 3, 0);
    chk("store9_ceiling", int'(store[9]), MAX_BAL);

    // Transfer: destination overflow, same account, insufficient, success
    txn(2, OP_TRANSFER, 3, 5, 50, 1, 400, 5, 0);
    txn(2, OP_TRANSFER, 3, 3, 10, 1, 400, 3, 0);
    txn(2, OP_TRANSFER, 3, 5, 401, 1, 400, 3, 0);
    txn(2, OP_TRANSFER, 3, 5, 40, 0, 360, 7, 2);
    chk("store5_after_xfer", int'(store[5]), 2040);
    chk("store3_after_xfer", int'(store[3]), 360);

    // Reset while reading the destination of a transfer
    set_term(2, OP_TRANSFER, 3, 5, 5);
    req[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rd_dst_busy", int'(busy), 1);
    chk("rd_dst_mem_rd", int'(mem_rd), 1);
    chk("rd_dst_addr", int'(mem_addr), 5);
    rst_n = 1'b0;
    #1;
    chk("arst_done", int'(done), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_mem_rd", int'(mem_rd), 0);
    chk("arst_mem_addr", int'(mem_addr), 0);
    chk("arst_err", int'(err), 0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_store3", int'(store[3]), 360);
    chk("abort_store5", int'(store[5]), 2040);

    // All four terminals requesting: order 0,1,2,3,0 from a fresh pointer
    for (int t = 0; t < N_TERM; t++) set_term(t, OP_BALANCE, 10 + t, 0, 0);
    push_exp(0, 0, 7);
    push_exp(1, 0, 107);
    push_exp(2, 0, 207);
    push_exp(3, 0, 307);
    push_exp(0, 0, 7);
    n_done = 0;
    cyc    = 0;
    last   = 0;
    req    = 4'hF;
    for (int c = 0; c < 200 && n_done < 5; c++) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        n_done++;
        if (n_done > 1) chk("rr_gap", cyc - last, 4);
        last = cyc;
        if (n_done == 5) req = '0;
      end
    end
    chk("rr_count", n_done, 5);
    @(negedge clk);

    // Lone requester held high is granted back to back
    push_exp(3, 0, 307);
    push_exp(3, 0, 307);
    n_done = 0;
    cyc    = 0;
    last   = 0;
    req[3] = 1'b1;
    for (int c = 0; c < 100 && n_done < 2; c++) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        n_done++;
        if (n_done > 1) chk("regrant_gap", cyc - last, 4);
        last = cyc;
        if (n_done == 2) req = '0;
      end
    end
    chk("regrant_count", n_done, 2);
    @(negedge clk);

`ifdef ATM_DAILY_LIMIT_EN
    txn(3, OP_WITHDRAW, 7, 0, 600, 0, 900, 4, 1);
    txn(3, OP_WITHDRAW, 7, 0, 500, 1, 900, 3, 0);
    sess_end[3] = 1'b1;
    @(negedge clk);
    sess_end[3] = 1'b0;
    @(negedge clk);
    txn(3, OP_WITHDRAW, 7, 0, 500, 0, 400, 4, 1);
`else
    txn(3, OP_WITHDRAW, 7, 0, 600, 0, 900, 4, 1);
    sess_end[3] = 1'b1;
    @(negedge clk);
    sess_end[3] = 1'b0;
    @(negedge clk);
    txn(3, OP_WITHDRAW, 7, 0, 500, 0, 400, 4, 1);
`endif
    chk("store7_final", int'(store[7]), 400);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
